// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius player-input checker.
//   symbol_t : button symbol 0/1/2
//   FAIL_*   : fail_code values reported to the game FSM
//   state_t  : checker FSM states
//   count_ones3 : population count of a 3-bit button vector
package genius_pkg;

    typedef enum logic [1:0] {
        SYM0 = 2'd0,
        SYM1 = 2'd1,
        SYM2 = 2'd2
    } symbol_t;

    localparam logic [1:0] FAIL_NONE    = 2'd0;
    localparam logic [1:0] FAIL_WRONG   = 2'd1;
    localparam logic [1:0] FAIL_TIMEOUT = 2'd2;
    localparam logic [1:0] FAIL_MULTI   = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StWaitPress,
        StWaitRelease,
        StCheck,
        StPass,
        StFail
    } state_t;

    function automatic logic [1:0] count_ones3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

endpackage

// File: rtl/genius_btn_debounce.sv
// Two-flop synchroniser plus shared stability counter for the 3-button bus.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : restart the stability count (owner FSM changes state)
//   raw[2:0]     : asynchronous active-high buttons
//   stable_vec   : synchronised button vector (bt_s)
//   stable_hit   : one-cycle strobe once bt_s has held its value for
//                  DEBOUNCE_CYCLES cycles since the last change or clear
module genius_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic [2:0] raw,
    output logic [2:0] stable_vec,
    output logic       stable_hit
);

    // One extra count value lets the counter park past the hit value so the
    // strobe fires only once per stable period.
    localparam int unsigned CntWidth = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [CntWidth-1:0] HitCount = CntWidth'(DEBOUNCE_CYCLES);

    logic [2:0]          sync_q;
    logic [2:0]          bt_s_q;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                changing;

    // bt_s is about to take a new value on the next edge.
    assign changing = (sync_q != bt_s_q);

    always_comb begin
        cnt_d = cnt_q;
        if (changing || clear) begin
            cnt_d = '0;
        end else if (cnt_q <= HitCount) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 3'b000;
            bt_s_q <= 3'b000;
            cnt_q  <= '0;
        end else begin
            sync_q <= raw;
            bt_s_q <= sync_q;
            cnt_q  <= cnt_d;
        end
    end

    assign stable_vec = bt_s_q;
    assign stable_hit = !changing && (cnt_q == HitCount);

endmodule

// File: rtl/genius_input_checker.sv
// Genius player-input checker: debounces bt0..bt2 into symbols and compares
// each accepted press, in order, against the first round_len sequence entries.
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   start, round_len     : begin a round of round_len (clamped to 16) symbols
//   bt0..bt2             : raw asynchronous buttons
//   seq_addr, seq_data   : combinational read port into the stored sequence
//   busy                 : round in progress
//   press_valid/_symbol  : accepted-press strobe and last accepted symbol
//   progress             : correct presses so far this round
//   ok, fail, fail_code  : round result pulses and reason
module genius_input_checker
    import genius_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] round_len,
    input  logic       bt0,
    input  logic       bt1,
    input  logic       bt2,
    output logic [3:0] seq_addr,
    input  logic [1:0] seq_data,
    output logic       busy,
    output logic       press_valid,
    output logic [1:0] press_symbol,
    output logic [4:0] progress,
    output logic       ok,
    output logic       fail,
    output logic [1:0] fail_code
);

    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  len_q, len_d;
    logic [3:0]  index_q, index_d;
    logic [4:0]  prog_q, prog_d;
    symbol_t     sym_q, sym_d;
    logic [1:0]  code_q, code_d;
    logic [31:0] tcnt_q, tcnt_d;

    logic [2:0]  stable_vec;
    logic        stable_hit;
    logic [1:0]  ones;

    genius_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock      (clock),
        .reset      (reset),
        .clear      (state_d != state_q),
        .raw        ({bt2, bt1, bt0}),
        .stable_vec (stable_vec),
        .stable_hit (stable_hit)
    );

    assign ones = count_ones3(stable_vec);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        index_d     = index_q;
        prog_d      = prog_q;
        sym_d       = sym_q;
        code_d      = code_q;
        tcnt_d      = tcnt_q;
        press_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = (round_len > 5'd16) ? 5'd16 : round_len;
                    index_d = 4'd0;
                    prog_d  = 5'd0;
                    code_d  = FAIL_NONE;
                    tcnt_d  = 32'd0;
                    state_d = (round_len == 5'd0) ? StPass : StWaitPress;
                end
            end
            StWaitPress: begin
                tcnt_d = tcnt_q + 32'd1;
                // Acceptance outranks a timeout landing in the same cycle.
                if (stable_hit && ones == 2'd1) begin
                    press_valid = 1'b1;
                    sym_d   = stable_vec[0] ? SYM0 : (stable_vec[1] ? SYM1 : SYM2);
                    state_d = StCheck;
                end else if (stable_hit && ones >= 2'd2) begin
                    code_d  = FAIL_MULTI;
                    state_d = StFail;
                end else if (tcnt_q == TimeoutLast) begin
                    code_d  = FAIL_TIMEOUT;
                    state_d = StFail;
                end
            end
            StCheck: begin
                // press symbols are 0..2, so a stored 3 can never match
                if (seq_data == sym_q) begin
                    prog_d  = prog_q + 5'd1;
                    state_d = StWaitRelease;
                end else begin
                    code_d  = FAIL_WRONG;
                    state_d = StFail;
                end
            end
            StWaitRelease: begin
                if (stable_hit && stable_vec == 3'b000) begin
                    if (prog_q == len_q) begin
                        state_d = StPass;
                    end else begin
                        index_d = index_q + 4'd1;
                        tcnt_d  = 32'd0;
                        state_d = StWaitPress;
                    end
                end
            end
            StPass:  state_d = StIdle;
            StFail:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            len_q   <= 5'd0;
            index_q <= 4'd0;
            prog_q  <= 5'd0;
            sym_q   <= SYM0;
            code_q  <= FAIL_NONE;
            tcnt_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            index_q <= index_d;
            prog_q  <= prog_d;
            sym_q   <= sym_d;
            code_q  <= code_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign seq_addr     = index_q;
    assign press_symbol = sym_q;
    assign progress     = prog_q;
    assign fail_code    = code_q;
    assign busy         = (state_q == StWaitPress) || (state_q == StWaitRelease) ||
                          (state_q == StCheck);
    assign ok           = (state_q == StPass);
    assign fail         = (state_q == StFail);

endmodule

// File: tb/tb_genius_input_checker.sv
// Directed bench for genius_input_checker with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100
// against the stored sequence 0,1,0,1,2,2 repeating.
module tb_genius_input_checker;

    logic       clock;
    logic       reset;
    logic       start;
    logic [4:0] round_len;
    logic       bt0, bt1, bt2;
    logic [3:0] seq_addr;
    logic [1:0] seq_data;
    logic       busy, press_valid, ok, fail;
    logic [1:0] press_symbol, fail_code;
    logic [4:0] progress;

    int total = 0;
    int bad   = 0;

    // Running totals kept by the monitor; tests compare deltas.
    int pv_total = 0;
    int ok_total = 0;
    int fail_total = 0;
    int last_pv_addr = -1;

    genius_input_checker #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (100)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .round_len    (round_len),
        .bt0          (bt0),
        .bt1          (bt1),
        .bt2          (bt2),
        .seq_addr     (seq_addr),
        .seq_data     (seq_data),
        .busy         (busy),
        .press_valid  (press_valid),
        .press_symbol (press_symbol),
        .progress     (progress),
        .ok           (ok),
        .fail         (fail),
        .fail_code    (fail_code)
    );

    function automatic logic [1:0] seq_sym(input int i);
        int r;
        r = i % 6;
        if (r <= 3) return 2'(r % 2);
        return 2'd2;
    endfunction

    function automatic logic [31:0] seq_word(input int n);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < n; i++) w = w | (32'(seq_sym(i)) << (2 * i));
        return w;
    endfunction

    assign seq_data = seq_sym(int'(seq_addr));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (press_valid) begin
            pv_total++;
            last_pv_addr = int'(seq_addr);
        end
        if (ok) ok_total++;
        if (fail) fail_total++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  len;
        int          npress;
        logic [31:0] syms;
        int          exp_pv;
        int          exp_ok;
        int          exp_fail;
        int          exp_code;
        int          exp_prog;
        int          exp_sym;
        int          exp_addr;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btn(input logic [2:0] mask);
        {bt2, bt1, bt0} = mask;
    endtask

    task automatic do_start(input logic [4:0] len);
        round_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press_sym(input int s, input int hold, input int rel);
        set_btn(3'(1 << s));
        tick_n(hold);
        set_btn(3'b000);
        tick_n(rel);
    endtask

    int pv0, ok0, f0, n;

    initial begin
        vecs[0] = '{5'd3,  3,  seq_word(3),  3,  1, 0, 0, 3,  0, 2};
        vecs[1] = '{5'd4,  2,  32'h8,        2,  0, 1, 1, 1,  2, 1};
        vecs[2] = '{5'd1,  1,  32'h1,        1,  0, 1, 1, 0,  1, 0};
        vecs[3] = '{5'd5,  5,  seq_word(5),  5,  1, 0, 0, 5,  2, 4};
        vecs[4] = '{5'd20, 16, seq_word(16), 16, 1, 0, 0, 16, 1, 15};
        vecs[5] = '{5'd6,  6,  seq_word(5),  6,  0, 1, 1, 5,  0, 5};

        reset = 1'b1;
        start = 1'b0;
        round_len = 5'd0;
        set_btn(3'b000);
        tick_n(3);
        check("reset_busy", int'(busy), 0);
        check("reset_ok", int'(ok), 0);
        check("reset_fail", int'(fail), 0);
        check("reset_code", int'(fail_code), 0);
        check("reset_prog", int'(progress), 0);
        check("reset_addr", int'(seq_addr), 0);
        reset = 1'b0;
        tick_n(2);

        // Table-driven rounds: each press held 10 cycles, released 10 cycles.
        for (int v = 0; v < 6; v++) begin
            pv0 = pv_total;
            ok0 = ok_total;
            f0  = fail_total;
            do_start(vecs[v].len);
            for (int p = 0; p < vecs[v].npress; p++)
                press_sym(int'((vecs[v].syms >> (2 * p)) & 32'h3), 10, 10);
            tick_n(5);
            check($sformatf("v%0d_pv", v), pv_total - pv0, vecs[v].exp_pv);
            check($sformatf("v%0d_ok", v), ok_total - ok0, vecs[v].exp_ok);
            check($sformatf("v%0d_fail", v), fail_total - f0, vecs[v].exp_fail);
            check($sformatf("v%0d_code", v), int'(fail_code), vecs[v].exp_code);
            check($sformatf("v%0d_prog", v), int'(progress), vecs[v].exp_prog);
            check($sformatf("v%0d_sym", v), int'(press_symbol), vecs[v].exp_sym);
            check($sformatf("v%0d_addr", v), last_pv_addr, vecs[v].exp_addr);
            check($sformatf("v%0d_busy", v), int'(busy), 0);
        end

        // Press latency and wrong-symbol fail timing (bt1 vs stored 0).
        do_start(5'd1);
        set_btn(3'b010);
        tick_n(5);
        check("lat_pv_early", int'(press_valid), 0);
        tick();
        check("lat_pv", int'(press_valid), 1);
        tick();
        check("lat_check_busy", int'(busy), 1);
        check("lat_check_nofail", int'(fail), 0);
        tick();
        check("lat_fail", int'(fail), 1);
        check("lat_code", int'(fail_code), 1);
        check("lat_busy_drop", int'(busy), 0);
        set_btn(3'b000);
        tick_n(8);

        // Timeout with no presses: fail 100 cycles after entering WAIT_PRESS.
        do_start(5'd2);
        n = 0;
        while (!fail && n < 200) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 100);
        check("timeout_code", int'(fail_code), 2);
        tick();

        // Press accepted in the same cycle the timeout would fire.
        do_start(5'd2);
        tick_n(93);
        set_btn(3'b001);
        tick_n(6);
        check("limit_pv", int'(press_valid), 1);
        check("limit_nofail", int'(fail), 0);
        tick();
        check("limit_check_nofail", int'(fail), 0);
        check("limit_busy", int'(busy), 1);
        tick_n(3);
        set_btn(3'b000);
        n = 0;
        while (!fail && n < 300) begin
            tick();
            n++;
        end
        check("timeout2_cycles", n, 107);
        check("timeout2_code", int'(fail_code), 2);
        check("timeout2_prog", int'(progress), 1);
        tick();

        // Multi-press: bt1 and bt2 together.
        pv0 = pv_total;
        f0  = fail_total;
        do_start(5'd2);
        set_btn(3'b110);
        tick_n(10);
        set_btn(3'b000);
        tick_n(3);
        check("multi_fail", fail_total - f0, 1);
        check("multi_code", int'(fail_code), 3);
        check("multi_pv", pv_total - pv0, 0);

        // Bounce: bt0 toggling every 2 cycles never settles.
        pv0 = pv_total;
        ok0 = ok_total;
        f0  = fail_total;
        do_start(5'd2);
        for (int i = 0; i < 5; i++) begin
            bt0 = 1'b1;
            tick_n(2);
            bt0 = 1'b0;
            tick_n(2);
        end
        tick_n(2);
        check("bounce_pv", pv_total - pv0, 0);
        check("bounce_fail", fail_total - f0, 0);
        check("bounce_busy", int'(busy), 1);
        reset = 1'b1;
        tick_n(2);
        reset = 1'b0;
        tick_n(2);
        check("bounce_abort_ok", ok_total - ok0, 0);
        check("bounce_abort_fail", fail_total - f0, 0);

        // round_len 0 passes one cycle after start.
        do_start(5'd0);
        check("len0_ok", int'(ok), 1);
        check("len0_busy", int'(busy), 0);
        tick();
        check("len0_ok_drop", int'(ok), 0);
        tick_n(2);

        // start while busy is ignored.
        pv0 = pv_total;
        ok0 = ok_total;
        do_start(5'd3);
        tick_n(2);
        do_start(5'd1);
        press_sym(0, 10, 10);
        press_sym(1, 10, 10);
        press_sym(0, 10, 10);
        tick_n(3);
        check("restart_prog", int'(progress), 3);
        check("restart_ok", ok_total - ok0, 1);
        check("restart_pv", pv_total - pv0, 3);

        // Reset mid-round after two correct presses.
        ok0 = ok_total;
        f0  = fail_total;
        do_start(5'd4);
        press_sym(0, 10, 10);
        press_sym(1, 10, 10);
        check("mid_prog_pre", int'(progress), 2);
        reset = 1'b1;
        tick();
        check("mid_busy", int'(busy), 0);
        check("mid_prog", int'(progress), 0);
        check("mid_sym", int'(press_symbol), 0);
        check("mid_addr", int'(seq_addr), 0);
        check("mid_pv", int'(press_valid), 0);
        check("mid_code", int'(fail_code), 0);
        tick();
        reset = 1'b0;
        tick_n(3);
        check("mid_no_ok", ok_total - ok0, 0);
        check("mid_no_fail", fail_total - f0, 0);
        ok0 = ok_total;
        do_start(5'd1);
        press_sym(0, 10, 10);
        tick_n(3);
        check("post_reset_ok", ok_total - ok0, 1);
        check("post_reset_prog", int'(progress), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
